// File: rtl/rf_wport_arbiter.sv
// Round-robin arbiter sharing the register file write port between two requesters.
// Optional ARB_PERF_CNT_EN adds conflict_cnt/drop_cnt performance counters.
module rf_wport_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 5,
    parameter int FIFO_DEPTH = 2
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req0_valid,
    output logic                  req0_ready,
    input  logic [ADDR_WIDTH-1:0] req0_addr,
    input  logic [DATA_WIDTH-1:0] req0_data,
    input  logic                  req1_valid,
    output logic                  req1_ready,
    input  logic [ADDR_WIDTH-1:0] req1_addr,
    input  logic [DATA_WIDTH-1:0] req1_data,
    output logic                  rf_wen,
    output logic [ADDR_WIDTH-1:0] rf_waddr,
    output logic [DATA_WIDTH-1:0] rf_wdata,
`ifdef ARB_PERF_CNT_EN
    output logic                  busy,
    output logic [31:0]           conflict_cnt,
    output logic [31:0]           drop_cnt
`else
    output logic                  busy
`endif
);

    localparam int PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int EW = ADDR_WIDTH + DATA_WIDTH;

    typedef logic [PW-1:0] ptr_t;
    typedef logic [PW:0]   cnt_t;
    typedef logic [EW-1:0] ent_t;

    localparam cnt_t FULL = cnt_t'(FIFO_DEPTH);

    ent_t mem0_q [FIFO_DEPTH];
    ent_t mem1_q [FIFO_DEPTH];

    ptr_t wptr0_q, wptr0_d, rptr0_q, rptr0_d;
    ptr_t wptr1_q, wptr1_d, rptr1_q, rptr1_d;
    cnt_t cnt0_q, cnt0_d, cnt1_q, cnt1_d;
    logic last1_q, last1_d;
    logic wen_q, wen_d;
    logic [ADDR_WIDTH-1:0] waddr_q, waddr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;

    logic ne0, ne1, acc0, acc1, push0, push1, gnt0, gnt1;
    ent_t head0, head1;

    assign ne0 = (cnt0_q != '0);
    assign ne1 = (cnt1_q != '0);

    assign req0_ready = resetn && (cnt0_q != FULL);
    assign req1_ready = resetn && (cnt1_q != FULL);

    assign acc0  = req0_valid && req0_ready;
    assign acc1  = req1_valid && req1_ready;
    assign push0 = acc0 && (req0_addr != '0);
    assign push1 = acc1 && (req1_addr != '0);

    // last1_q set means requester 1 won last, so requester 0 wins a tie
    assign gnt0 = ne0 && (!ne1 || last1_q);
    assign gnt1 = ne1 && !gnt0;

    assign head0 = mem0_q[rptr0_q];
    assign head1 = mem1_q[rptr1_q];

    assign rf_wen   = wen_q;
    assign rf_waddr = waddr_q;
    assign rf_wdata = wdata_q;
    assign busy     = ne0 || ne1 || wen_q;

    // Next-state for FIFO pointers, arbitration history and output register
    always_comb begin
        wptr0_d = wptr0_q + ptr_t'(push0);
        wptr1_d = wptr1_q + ptr_t'(push1);
        rptr0_d = rptr0_q + ptr_t'(gnt0);
        rptr1_d = rptr1_q + ptr_t'(gnt1);
        cnt0_d  = cnt0_q + cnt_t'(push0) - cnt_t'(gnt0);
        cnt1_d  = cnt1_q + cnt_t'(push1) - cnt_t'(gnt1);
        last1_d = last1_q;
        wen_d   = gnt0 || gnt1;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        if (gnt0) begin
            last1_d = 1'b0;
            waddr_d = head0[EW-1 -: ADDR_WIDTH];
            wdata_d = head0[DATA_WIDTH-1:0];
        end else if (gnt1) begin
            last1_d = 1'b1;
            waddr_d = head1[EW-1 -: ADDR_WIDTH];
            wdata_d = head1[DATA_WIDTH-1:0];
        end
    end

    // Control state register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!resetn) begin
            wptr0_q <= '0;
            wptr1_q <= '0;
            rptr0_q <= '0;
            rptr1_q <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            last1_q <= 1'b1;
            wen_q   <= 1'b0;
            waddr_q <= '0;
            wdata_q <= '0;
        end else begin
            wptr0_q <= wptr0_d;
            wptr1_q <= wptr1_d;
            rptr0_q <= rptr0_d;
            rptr1_q <= rptr1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            last1_q <= last1_d;
            wen_q   <= wen_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
        end
    end

    // FIFO storage; validity is tracked by the counts, so no reset needed
    always_ff @(posedge clk) begin
        if (push0) mem0_q[wptr0_q] <= {req0_addr, req0_data};
        if (push1) mem1_q[wptr1_q] <= {req1_addr, req1_data};
    end

`ifdef ARB_PERF_CNT_EN
    logic [31:0] conf_q, conf_d, drop_q, drop_d;
    logic        drop0, drop1;

    assign drop0        = acc0 && (req0_addr == '0);
    assign drop1        = acc1 && (req1_addr == '0);
    assign conflict_cnt = conf_q;
    assign drop_cnt     = drop_q;

    // Counters wrap naturally at 2^32
    always_comb begin
        conf_d = conf_q + 32'(ne0 && ne1);
        drop_d = drop_q + 32'(drop0) + 32'(drop1);
    end

    // Performance counter registers
    always_ff @(posedge clk) begin
        if (!resetn) begin
            conf_q <= '0;
            drop_q <= '0;
        end else begin
            conf_q <= conf_d;
            drop_q <= drop_d;
        end
    end
`endif

endmodule

// File: tb/tb_rf_wport_arbiter.sv
// Directed self-checking bench for rf_wport_arbiter.
// Vector table plus hand sequences for backpressure, reset and wrap.
module tb_rf_wport_arbiter;

    logic        clk = 1'b0;
    logic        resetn;
    logic        req0_valid, req0_ready;
    logic [4:0]  req0_addr;
    logic [31:0] req0_data;
    logic        req1_valid, req1_ready;
    logic [4:0]  req1_addr;
    logic [31:0] req1_data;
    logic        rf_wen;
    logic [4:0]  rf_waddr;
    logic [31:0] rf_wdata;
    logic        busy;
`ifdef ARB_PERF_CNT_EN
    logic [31:0] conflict_cnt, drop_cnt;
`endif

    int nchk = 0;
    int nerr = 0;

    rf_wport_arbiter dut (
        .clk        (clk),
        .resetn     (resetn),
        .req0_valid (req0_valid),
        .req0_ready (req0_ready),
        .req0_addr  (req0_addr),
        .req0_data  (req0_data),
        .req1_valid (req1_valid),
        .req1_ready (req1_ready),
        .req1_addr  (req1_addr),
        .req1_data  (req1_data),
        .rf_wen     (rf_wen),
        .rf_waddr   (rf_waddr),
        .rf_wdata   (rf_wdata),
`ifdef ARB_PERF_CNT_EN
        .busy         (busy),
        .conflict_cnt (conflict_cnt),
        .drop_cnt     (drop_cnt)
`else
        .busy       (busy)
`endif
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v0;
        logic [4:0]  a0;
        logic [31:0] d0;
        logic        v1;
        logic [4:0]  a1;
        logic [31:0] d1;
        logic        r0;
        logic        r1;
        logic        wen;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        bsy;
    } vec_t;

    vec_t tbl[12];
    logic [36:0] exp0[$];
    logic [36:0] exp1[$];

    task automatic check(input string nm, input logic [63:0] act,
                         input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_in();
        req0_valid = 0; req0_addr = 0; req0_data = 0;
        req1_valid = 0; req1_addr = 0; req1_data = 0;
    endtask

    task automatic do_reset();
        idle_in();
        resetn = 0;
        tick();
        resetn = 1;
    endtask

    function automatic vec_t mk(logic v0, logic [4:0] a0, logic [31:0] d0,
                                logic v1, logic [4:0] a1, logic [31:0] d1,
                                logic r0, logic r1, logic wen,
                                logic [4:0] wa, logic [31:0] wd, logic bsy);
        vec_t v;
        v.v0 = v0; v.a0 = a0; v.d0 = d0;
        v.v1 = v1; v.a1 = a1; v.d1 = d1;
        v.r0 = r0; v.r1 = r1;
        v.wen = wen; v.wa = wa; v.wd = wd; v.bsy = bsy;
        return v;
    endfunction

    function automatic logic [4:0] ad0(int i); return 5'(1 + i); endfunction
    function automatic logic [4:0] ad1(int i); return 5'(16 + i); endfunction
    function automatic logic [31:0] dt0(int i); return 32'hA000_0000 + i; endfunction
    function automatic logic [31:0] dt1(int i); return 32'hB000_0000 + i; endfunction

    task automatic sb_check();
        if (rf_waddr < 5'd16) begin
            check("bp_extra0", 64'(exp0.size() == 0), 0);
            if (exp0.size() != 0)
                check("bp_wr0", {rf_waddr, rf_wdata}, exp0.pop_front());
        end else begin
            check("bp_extra1", 64'(exp1.size() == 0), 0);
            if (exp1.size() != 0)
                check("bp_wr1", {rf_waddr, rf_wdata}, exp1.pop_front());
        end
    endtask

    initial begin
        int i0, i1;
        logic acc0, acc1, done;
        localparam int N = 8;

        // columns: v0 a0 d0 | v1 a1 d1 | rdy0 rdy1 | wen waddr wdata busy
        tbl[0]  = mk(1, 1, 'h11, 1, 3, 'h33, 1, 1, 0, 0, 0, 1);
        tbl[1]  = mk(1, 2, 'h22, 1, 4, 'h44, 1, 1, 1, 1, 'h11, 1);
        tbl[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0, 1, 3, 'h33, 1);
        tbl[3]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 2, 'h22, 1);
        tbl[4]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 4, 'h44, 1);
        tbl[5]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 4, 'h44, 0);
        tbl[6]  = mk(1, 5, 'hDEADBEEF, 0, 0, 0, 1, 1, 0, 4, 'h44, 1);
        tbl[7]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 1, 5, 'hDEADBEEF, 1);
        tbl[8]  = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 'hDEADBEEF, 0);
        tbl[9]  = mk(1, 0, 'h1234, 0, 0, 0, 1, 1, 0, 5, 'hDEADBEEF, 0);
        tbl[10] = mk(0, 0, 0, 0, 0, 0, 1, 1, 0, 5, 'hDEADBEEF, 0);
        tbl[11] = mk(0, 0, 0, 1, 0, 'h55, 1, 1, 0, 5, 'hDEADBEEF, 0);

        // reset state
        idle_in();
        resetn = 0;
        tick();
        tick();
        check("rst_rdy0_low", req0_ready, 0);
        check("rst_rdy1_low", req1_ready, 0);
        check("rst_wen", rf_wen, 0);
        check("rst_waddr", rf_waddr, 0);
        check("rst_wdata", rf_wdata, 0);
        check("rst_busy", busy, 0);
        resetn = 1;
        #1;
        check("rst_rdy0_rel", req0_ready, 1);
        check("rst_rdy1_rel", req1_ready, 1);

        // contention, single write, x0 filter
        for (int i = 0; i < 12; i++) begin
            req0_valid = tbl[i].v0; req0_addr = tbl[i].a0; req0_data = tbl[i].d0;
            req1_valid = tbl[i].v1; req1_addr = tbl[i].a1; req1_data = tbl[i].d1;
            #1;
            check($sformatf("vec%0d_rdy0", i), req0_ready, tbl[i].r0);
            check($sformatf("vec%0d_rdy1", i), req1_ready, tbl[i].r1);
            tick();
            check($sformatf("vec%0d_wen", i), rf_wen, tbl[i].wen);
            check($sformatf("vec%0d_waddr", i), rf_waddr, tbl[i].wa);
            check($sformatf("vec%0d_wdata", i), rf_wdata, tbl[i].wd);
            check($sformatf("vec%0d_busy", i), busy, tbl[i].bsy);
        end
        idle_in();
`ifdef ARB_PERF_CNT_EN
        check("perf_conflict", conflict_cnt, 3);
        check("perf_drop", drop_cnt, 2);
`endif

        // backpressure with scoreboard
        do_reset();
        i0 = 0; i1 = 0; done = 0;
        req0_valid = 1; req0_addr = ad0(0); req0_data = dt0(0);
        req1_valid = 1; req1_addr = ad1(0); req1_data = dt1(0);
        for (int k = 0; k < 60 && !done; k++) begin
            #1;
            if (k < 8) begin
                check($sformatf("bp_rdy0_%0d", k), req0_ready,
                      (k < 2) ? 1 : ((k % 2) == 0));
                check($sformatf("bp_rdy1_%0d", k), req1_ready,
                      (k < 2) ? 1 : ((k % 2) == 1));
            end
            acc0 = req0_valid && req0_ready;
            acc1 = req1_valid && req1_ready;
            tick();
            if (rf_wen) sb_check();
            if (acc0) begin exp0.push_back({ad0(i0), dt0(i0)}); i0++; end
            if (acc1) begin exp1.push_back({ad1(i1), dt1(i1)}); i1++; end
            req0_valid = (i0 < N); req0_addr = ad0(i0); req0_data = dt0(i0);
            req1_valid = (i1 < N); req1_addr = ad1(i1); req1_data = dt1(i1);
            if (i0 >= N && i1 >= N && !busy) done = 1;
        end
        idle_in();
        check("bp_drained", busy, 0);
        check("bp_sent0", i0, N);
        check("bp_sent1", i1, N);
        check("bp_left0", exp0.size(), 0);
        check("bp_left1", exp1.size(), 0);

        // reset in the middle of traffic
        req0_valid = 1; req0_addr = 9;  req0_data = 'h99;
        req1_valid = 1; req1_addr = 10; req1_data = 'hAA;
        tick();
        req0_addr = 11; req0_data = 'hBB;
        req1_addr = 12; req1_data = 'hCC;
        tick();
        check("mid_busy_pre", busy, 1);
        resetn = 0;
        #1;
        check("mid_rdy0_low", req0_ready, 0);
        check("mid_rdy1_low", req1_ready, 0);
        tick();
        check("mid_wen", rf_wen, 0);
        check("mid_waddr", rf_waddr, 0);
        check("mid_wdata", rf_wdata, 0);
        check("mid_busy", busy, 0);
        idle_in();
        resetn = 1;
        #1;
        check("mid_rdy0_rel", req0_ready, 1);
        check("mid_rdy1_rel", req1_ready, 1);
        for (int k = 0; k < 3; k++) begin
            tick();
            check($sformatf("mid_nowr%0d", k), rf_wen, 0);
        end
        req0_valid = 1; req0_addr = 7; req0_data = 'h77;
        req1_valid = 1; req1_addr = 8; req1_data = 'h88;
        tick();
        idle_in();
        check("post_c0_wen", rf_wen, 0);
        tick();
        check("post_c1", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd7, 32'h77});
        tick();
        check("post_c2", {rf_wen, rf_waddr, rf_wdata}, {1'b1, 5'd8, 32'h88});
        tick();
        check("post_c3_wen", rf_wen, 0);

        // wrap-around: 10 back-to-back writes on requester 0
        for (int k = 0; k < 13; k++) begin
            req0_valid = (k < 10);
            req0_addr = 5'(k + 1);
            req0_data = 32'((k + 1) * 3);
            #1;
            if (k < 10) check($sformatf("wrap_rdy%0d", k), req0_ready, 1);
            tick();
            if (k >= 1 && k <= 10)
                check($sformatf("wrap_wr%0d", k),
                      {rf_wen, rf_waddr, rf_wdata},
                      {1'b1, 5'(k), 32'(k * 3)});
            else
                check($sformatf("wrap_idle%0d", k), rf_wen, 0);
        end
        idle_in();
        check("wrap_busy", busy, 0);

        $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
        $finish;
    end

endmodule
